spi_slave_ctrl: RTL and testbench
=================================

// Module: spi_slave_ctrl
// PURPOSE
//  SPI slave front end of the dual-port RAM subsystem; counterpart of the RAM's din/rx_valid/dout/tx_valid port.
//  Deserialises MOSI frames into 10-bit words and presents them to the RAM with a one-cycle rx_valid pulse.
//  For read-data frames, waits for the RAM's tx_valid and serialises the returned byte on MISO.
//  MOSI is sampled and MISO is driven on posedge clk; SS_n frames each transaction.
// PARAMETERS
//  WORD_W  10  width of word sent to RAM ({cmd[1:0], payload[7:0]})
//  DATA_W  8   width of read data returned by RAM and shifted out on MISO
// PORTS
//  clk       in   1       system clock; also the serial bit clock
//  rst_n     in   1       asynchronous active-low reset
//  SS_n      in   1       slave select, active low; high = frame end/abort
//  MOSI      in   1       serial data in, MSB first
//  MISO      out  1       serial data out, MSB first; 0 when not shifting
//  rx_data   out  WORD_W  word to RAM, held stable until next rx_valid
//  rx_valid  out  1       one-cycle strobe: rx_data valid
//  tx_data   in   DATA_W  read byte from RAM
//  tx_valid  in   1       tx_data valid; honoured only in READ_DATA wait phase
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  IDLE: SS_n=0 sampled -> CHK_CMD next cycle. MOSI ignored in IDLE.
//  CHK_CMD: MOSI sampled as word bit 9; count=1. MOSI=0 -> WRITE;
//   MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
//  WRITE/READ_ADD/READ_DATA: shift MOSI into bits 8..0 MSB first, one bit per cycle (9 cycles).
//   Cycle after bit 0 sampled: rx_data <= full 10-bit word, rx_valid=1 for exactly that one cycle.
//   rx_data forwarded unchecked; bits [9:8] decoded by the RAM only.
//  WRITE: after rx_valid, remain in state ignoring MOSI until SS_n=1. rd_addr_seen unchanged.
//  READ_ADD: with rx_valid, set rd_addr_seen=1; then idle in state until SS_n=1.
//  READ_DATA: with rx_valid, clear rd_addr_seen; then wait indefinitely for tx_valid.
//   On first tx_valid=1: latch tx_data; MISO drives bit 7 on next cycle, down to bit 0 over 8 cycles.
//   After bit 0, MISO=0 and further tx_valid ignored until the next READ_DATA frame.
//   tx_valid asserted before the wait phase (or outside READ_DATA) is ignored, not queued.
//  SS_n=1 in any non-IDLE state: next state IDLE, counter cleared, MISO=0 next cycle.
//   Aborted frame (fewer than 10 bits) produces no rx_valid, leaves rd_addr_seen unchanged.
//   Abort during MISO shift truncates output; rd_addr_seen stays cleared.
//  Back-to-back frames: SS_n high for >=1 cycle between frames; IDLE->CHK_CMD latency 1 cycle.
//  Frame length: 1 (SS_n fall) + 1 (CHK_CMD) + 9 bits; rx_valid in cycle 12 counting SS_n-low as cycle 1.
//  rst_n asserted mid-frame: immediate return to reset values; no partial rx_valid.
// TESTING
//  Write addr: SS_n=0, MOSI bits 0,0,0_1010_1010 (10 bits) -> one rx_valid, rx_data=10'h0AA, MISO=0.
//  Write data: frame 0,1,1100_0011 -> rx_data=10'h1C3; rd_addr_seen stays 0.
//  Read addr then read data: frame 1,0,0000_0101 -> rx_data=10'h205 (READ_ADD);
//   frame 1,1,xxxx_xxxx -> READ_DATA, rx_valid with rx_data[9:8]=2'b11;
//   tx_valid=1 with tx_data=8'hA5 after 3 cycles -> MISO=1,0,1,0,0,1,0,1 on 8 consecutive cycles.
//  Abort: SS_n high after 5 bits of write frame -> no rx_valid, state IDLE next cycle.
//   Next full frame decodes normally.
//  Spurious tx_valid: pulse during WRITE and during IDLE -> MISO stays 0.
//   Second tx_valid after an 8-bit READ_DATA shift -> ignored.
//  Async reset mid-READ_DATA shift (after 3 MISO bits) -> MISO=0, rx_valid=0 immediately.
//   rd_addr_seen=0, so next 1-prefixed frame enters READ_ADD.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the dual-port RAM subsystem.
// Collects 10-bit words from MOSI and hands each one to the RAM with a one-cycle
// rx_valid strobe. In a read-data frame it then waits for the RAM's tx_valid and
// shifts the returned byte out on MISO, MSB first. MOSI is sampled and MISO is
// driven on the same clock edge.
module spi_slave_ctrl #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;         // word bits received so far
    logic [WORD_W-2:0]   shreg_q, shreg_d;     // bits 9..1 while assembling
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rd_seen_q, rd_seen_d; // a read address has been sent
    logic                miso_q, miso_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;     // remaining read bits, MSB next
    logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;   // MISO bits still to drive
    logic                tx_done_q, tx_done_d; // byte already taken this frame

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: SS_n high aborts any frame; first word bit picks the frame type
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!SS_n) state_d = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)           state_d = IDLE;
                else if (!MOSI)     state_d = WRITE;
                else if (rd_seen_q) state_d = READ_DATA;
                else                state_d = READ_ADD;
            end
            default: if (SS_n) state_d = IDLE;
        endcase
    end

    // Datapath next values: word assembly, rx strobe, read-byte serialiser
    always_comb begin
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_seen_d  = rd_seen_q;
        miso_d     = 1'b0;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_done_d  = tx_done_q;
        if (state_q == IDLE || SS_n) begin
            // Aborted frames drop partial words and leave rd_seen alone
            cnt_d     = '0;
            tx_cnt_d  = '0;
            tx_done_d = 1'b0;
        end else if (state_q == CHK_CMD) begin
            shreg_d = {{(WORD_W-2){1'b0}}, MOSI};
            cnt_d   = CNT_W'(1);
        end else if (cnt_q != FULL) begin
            shreg_d = {shreg_q[WORD_W-3:0], MOSI};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
                rx_data_d  = {shreg_q, MOSI};
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD)  rd_seen_d = 1'b1;
                if (state_q == READ_DATA) rd_seen_d = 1'b0;
            end
        end else if (state_q == READ_DATA) begin
            // Word delivered: shift an accepted byte, or take the first tx_valid
            if (tx_cnt_q != '0) begin
                miso_d   = tx_sh_q[DATA_W-1];
                tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q - TXC_W'(1);
            end else if (tx_valid && !tx_done_q) begin
                miso_d    = tx_data[DATA_W-1];
                tx_sh_d   = {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt_d  = TXC_W'(DATA_W - 1);
                tx_done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            miso_q     <= 1'b0;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_seen_q  <= rd_seen_d;
            miso_q     <= miso_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_done_q  <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: directed frames; expected rx words and per-cycle
// MISO values are queued by the driver and checked by an independent monitor.
module tb_spi_slave_ctrl;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks = 0;
    int errors = 0;

    logic [9:0] rxq[$];
    logic       misoq[$];

    spi_slave_ctrl #(.WORD_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares DUT outputs against queued expectations on negedge
    always @(negedge clk) begin
        if (misoq.size() > 0) begin
            logic em;
            em = misoq.pop_front();
            checks++;
            if (MISO !== em) begin
                errors++;
                $display("FAIL miso @%0t: got %b want %b", $time, MISO, em);
            end
        end
        if (rx_valid === 1'b1) begin
            checks++;
            if (rxq.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected @%0t: got rx_valid with %h, want none", $time, rx_data);
            end else begin
                logic [9:0] ew;
                ew = rxq.pop_front();
                if (rx_data !== ew) begin
                    errors++;
                    $display("FAIL rx_data @%0t: got %h want %h", $time, rx_data, ew);
                end
            end
        end
    end

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One clock: drive inputs, expect MISO value em right after the posedge
    task automatic step(input logic ss, input logic mosi, input logic txv,
                        input logic [7:0] txd, input logic em);
        SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
        @(posedge clk);
        misoq.push_back(em);
        @(negedge clk);
    endtask

    // SS_n fall cycle, then nbits word bits MSB first; full frames expect rx
    task automatic frame(input logic [9:0] w, input int nbits);
        if (nbits == 10) rxq.push_back(w);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < nbits; i++) step(1'b0, w[9-i], 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic shift_byte(input logic [7:0] b);
        // tx_valid accepted this cycle: bit 7 appears, then bits 6..0
        step(1'b0, 1'b0, 1'b1, b, b[7]);
        for (int i = 6; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 8'h00, b[i]);
    endtask

    initial begin
        logic [7:0] rb;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #12;
        check("reset_miso", {9'b0, MISO}, 10'h000);
        check("reset_rx_valid", {9'b0, rx_valid}, 10'h000);
        check("reset_rx_data", rx_data, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Write address, then spurious tx_valid in WRITE and in IDLE
        frame(10'h0AA, 10);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);

        // Write data; rd_addr_seen stays clear
        frame(10'h1C3, 10);
        idle(1);

        // Read address, then read data with byte A5 after 3 wait cycles
        frame(10'h205, 10);
        idle(1);
        frame(10'h35A, 10);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        shift_byte(8'hA5);
        // Byte already sent: a second tx_valid is ignored
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        idle(2);

        // Aborted write after 5 bits, one idle cycle, then a full frame
        frame(10'h0F0, 5);
        idle(1);
        frame(10'h055, 10);
        idle(1);

        // Read pair with async reset after 3 MISO bits of 3C (0,0,1)
        frame(10'h210, 10);
        idle(1);
        frame(10'h300, 10);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rb = 8'h3C;
        step(1'b0, 1'b0, 1'b1, rb, rb[7]);
        step(1'b0, 1'b0, 1'b0, 8'h00, rb[6]);
        step(1'b0, 1'b0, 1'b0, 8'h00, rb[5]);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_miso", {9'b0, MISO}, 10'h000);
        check("async_rst_rx_valid", {9'b0, rx_valid}, 10'h000);
        check("async_rst_rx_data", rx_data, 10'h000);
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // rd_addr_seen was cleared by reset: this frame is a READ_ADD, so
        // tx_valid afterwards must not produce MISO data
        frame(10'h2AB, 10);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        idle(3);

        check("rx_queue_drained", 10'(rxq.size()), 10'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
